timer_unit: RTL
===============

# timer_unit

Memory-mapped programmable down-counter timer on the MonkeyMIPS data bus, alongside data_ram and peripheral. It decodes word accesses from the core's memory stage, counts down from a software-set period, and raises a level interrupt. The interrupt drives bit 0 of the core's 6-bit `int_i` vector, where it is the source of `timer_int`.

## Interface
Parameters:
- `BASE_ADDR`, default 32'h1000_0000: 32-byte-aligned base of the register window.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `we`  in  1  write strobe, already qualified for the peripheral space.
- `addr`  in  32  byte address from the memory stage.
- `wdata`  in  32  write data.
- `rdata`  out  32  read data, combinational from registers.
- `timer_int`  out  1  level interrupt: `pending & CTRL.ie`.

## Operation
Window hit: `addr[31:5] == BASE_ADDR[31:5]`. Register select: `addr[4:2]`.

Register map:
- 0x00 CTRL:
  - bit0 `en`: counting enabled.
  - bit1 `ie`: interrupt enable.
  - bit2 `ar`: 1 = auto-reload, 0 = one-shot.
  - Other bits read 0.
- 0x04 PERIOD, 32 bits. A write loads both PERIOD and COUNT.
- 0x08 COUNT, 32 bits, read/write.
- 0x0C STATUS: bit0 `pending`. Writing 1 to bit0 clears it; writing 0 has no effect.
- 0x10 PRESCALE: present only with the macro (see Configuration).
- Offsets 0x14–0x1C, and any address outside the window, read 0. Writes to them are ignored.

Counting:
- State machine: STOPPED (`en`=0) and RUNNING (`en`=1).
- On each tick in RUNNING:
  - COUNT != 0: decrement COUNT.
  - COUNT == 0: this is an expiry. Set `pending`.
    - If `ar`=1: reload COUNT from PERIOD.
    - If `ar`=0: COUNT stays 0, `en` clears, and the state returns to STOPPED.
- Setting `en` does not reload COUNT. Counting resumes from the current COUNT.
- The expiry interval is PERIOD+1 ticks. PERIOD=0 with `ar`=1 expires on every tick.
- Arithmetic is unsigned 32-bit. COUNT never wraps below 0.

Collisions in the same cycle:
- Bus write to CTRL vs one-shot clearing `en`: the bus write wins.
- Bus write to COUNT or PERIOD vs decrement/reload: the bus write wins.
- STATUS clear vs expiry: the expiry wins, so `pending` stays 1.

Reset: CTRL=0, PERIOD=0, COUNT=0, pending=0, PRESCALE=0, prescale counter=0. Consequently `timer_int`=0 and `rdata`=0. A reset mid-run aborts counting immediately.

## Timing
- Writes take effect at the clock edge where `we` is sampled high.
- Reads are combinational and show register values as of the current cycle.
- An expiry evaluated at edge N makes `pending` and `timer_int` high after edge N. `timer_int` is driven straight from flops, with no extra stage.
- Clearing `ie` or `pending` at edge N drops `timer_int` after edge N.
- Without a prescaler, one tick equals one clock cycle while RUNNING.
- After writing CTRL.en=1 at edge N, the first decrement occurs at edge N+1.

## Configuration
Macro: `TIMER_PRESCALER_EN`.

When defined:
- PRESCALE (0x10) is a 16-bit read/write register; upper bits read 0.
- A prescale counter runs only while RUNNING and produces one tick every PRESCALE+1 cycles.
- The prescale counter restarts from 0 on any write to CTRL or PRESCALE.

When not defined:
- A tick occurs every cycle.
- 0x10 reads 0 and writes are ignored.
- No prescaler logic is synthesized.

## Structure
- Shared package `timer_pkg`:
  - register offsets (`TMR_CTRL`, `TMR_PERIOD`, `TMR_COUNT`, `TMR_STATUS`, `TMR_PRESCALE`);
  - CTRL bit indices;
  - the state encoding.
- One natural sub-module, `timer_prescaler`, containing the prescale counter and the tick output. It is instantiated only under `TIMER_PRESCALER_EN`; otherwise tick is tied to 1.

## Test plan
- Periodic: write PERIOD=3, then CTRL=3'b111 → `timer_int` high 4 cycles after the CTRL write; after a STATUS clear, it re-asserts every 4 cycles.
- One-shot: PERIOD=2, CTRL=3'b011 → a single expiry after 3 cycles; CTRL reads 3'b010; COUNT holds 0; no further expiry in 20 cycles.
- Collision: issue the STATUS write-1 on the exact cycle of an expiry → `pending` remains 1 and `timer_int` stays high.
- Masking and decode:
  - With `ie`=0, an expiry sets `pending` but `timer_int` stays 0.
  - Setting `ie` afterwards → `timer_int` goes high the next cycle.
  - A read of BASE+0x18 returns 0.
- Reset mid-run: assert `rst` while COUNT=5 and RUNNING → all registers read 0, `timer_int`=0, and no expiry follows.
- With `TIMER_PRESCALER_EN`: PRESCALE=1, PERIOD=2, CTRL=3'b111 → expiry every 6 cycles.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped down-counter timer: register
// offsets, CTRL bit positions and the run-state encoding.
package timer_pkg;

    localparam logic [4:0] TMR_CTRL     = 5'h00;
    localparam logic [4:0] TMR_PERIOD   = 5'h04;
    localparam logic [4:0] TMR_COUNT    = 5'h08;
    localparam logic [4:0] TMR_STATUS   = 5'h0C;
    localparam logic [4:0] TMR_PRESCALE = 5'h10;

    localparam int CTRL_EN = 0;
    localparam int CTRL_IE = 1;
    localparam int CTRL_AR = 2;

    typedef enum logic {
        ST_STOPPED = 1'b0,
        ST_RUNNING = 1'b1
    } tmr_state_e;

endpackage

// File: rtl/timer_prescaler.sv
// Prescale counter for timer_unit: emits one tick every prescale+1 cycles
// while run is high; restart forces the count back to 0.
module timer_prescaler
    import timer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        restart,
    input  logic [15:0] prescale,
    output logic        tick
);

    logic [15:0] cnt;

    assign tick = run && (cnt == prescale);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (restart) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= tick ? 16'd0 : cnt + 16'd1;
        end
    end

endmodule

// File: rtl/timer_unit.sv
// Memory-mapped programmable down-counter timer with level interrupt.
// Optional prescaler is built only when TIMER_PRESCALER_EN is defined.
//
//   state      | meaning
//   -----------+----------------------------------------------
//   ST_STOPPED | CTRL.en = 0, COUNT frozen
//   ST_RUNNING | CTRL.en = 1, COUNT decrements on every tick
module timer_unit
    import timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        timer_int
);

    tmr_state_e  state, state_next;
    logic        ie, ar, pending, pending_next;
    logic [31:0] period, count, count_next;
    logic        hit, tick, expire;
    logic [4:0]  sel;
    logic        wr_ctrl, wr_period, wr_count, wr_status;
    logic        unused_addr;

    assign hit         = (addr[31:5] == BASE_ADDR[31:5]);
    assign sel         = {addr[4:2], 2'b00};
    assign wr_ctrl     = we && hit && (sel == TMR_CTRL);
    assign wr_period   = we && hit && (sel == TMR_PERIOD);
    assign wr_count    = we && hit && (sel == TMR_COUNT);
    assign wr_status   = we && hit && (sel == TMR_STATUS);
    assign unused_addr = ^addr[1:0];

`ifdef TIMER_PRESCALER_EN
    logic [15:0] prescale;
    logic        wr_prescale;

    assign wr_prescale = we && hit && (sel == TMR_PRESCALE);

    always_ff @(posedge clk) begin
        if (rst) begin
            prescale <= '0;
        end else if (wr_prescale) begin
            prescale <= wdata[15:0];
        end
    end

    timer_prescaler u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .run      (state == ST_RUNNING),
        .restart  (wr_ctrl || wr_prescale),
        .prescale (prescale),
        .tick     (tick)
    );
`else
    assign tick = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_STOPPED;
        end else begin
            state <= state_next;
        end
    end

    // A CTRL write overrides the one-shot self-stop in the same cycle.
    always_comb begin
        state_next = state;
        if (wr_ctrl) begin
            state_next = wdata[CTRL_EN] ? ST_RUNNING : ST_STOPPED;
        end else if (expire && !ar) begin
            state_next = ST_STOPPED;
        end
    end

    always_comb begin
        expire     = (state == ST_RUNNING) && tick && (count == 32'd0);
        count_next = count;
        if ((state == ST_RUNNING) && tick) begin
            if (count != 32'd0) begin
                count_next = count - 32'd1;
            end else if (ar) begin
                count_next = period;
            end
        end
        if (wr_period || wr_count) begin
            count_next = wdata;
        end
        // Expiry beats a simultaneous STATUS clear.
        pending_next = pending;
        if (wr_status && wdata[0]) begin
            pending_next = 1'b0;
        end
        if (expire) begin
            pending_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ie      <= 1'b0;
            ar      <= 1'b0;
            period  <= '0;
            count   <= '0;
            pending <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                ie <= wdata[CTRL_IE];
                ar <= wdata[CTRL_AR];
            end
            if (wr_period) begin
                period <= wdata;
            end
            count   <= count_next;
            pending <= pending_next;
        end
    end

    assign timer_int = pending && ie;

    always_comb begin
        rdata = '0;
        if (hit) begin
            case (sel)
                TMR_CTRL:     rdata = {29'd0, ar, ie, (state == ST_RUNNING)};
                TMR_PERIOD:   rdata = period;
                TMR_COUNT:    rdata = count;
                TMR_STATUS:   rdata = {31'd0, pending};
`ifdef TIMER_PRESCALER_EN
                TMR_PRESCALE: rdata = {16'd0, prescale};
`endif
                default:      rdata = '0;
            endcase
        end
    end

endmodule
